// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   XLEN             : architectural register / address width
//   INSN_BYTES       : size of one instruction, the sequential PC step
//   RESET_PC_DEFAULT : default fetch address after reset
//   pc_state_e       : fetch-controller states (BOOT, FETCH, HALT)
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } pc_state_e;

    // A redirect target is usable only if it lands on an instruction boundary.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_ctrl.sv
// Fetch-stage program-counter controller.
// Owns the fetch PC and sequences it against the instruction-memory
// request/grant handshake, hazard stalls and EX-stage redirects.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous, active-high reset
//   stall        in   hazard stall: hold PC, suppress request
//   redirect     in   EX-stage taken branch/jump
//   redirect_pc  in   redirect target, valid with redirect
//   imem_gnt     in   memory accepts imem_addr this cycle
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (= current PC)
//   if_valid     out  instruction at if_pc accepted this cycle
//   if_pc        out  PC of the accepted fetch (0 when if_valid=0)
//   flush        out  registered one-cycle pulse after a redirect
//   halted       out  sticky, set by a misaligned redirect
//   fetch_cnt    out  number of accepted fetches (wraps silently)
module pc_ctrl
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             imem_gnt,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    output logic             if_valid,
    output logic [XLEN-1:0]  if_pc,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q,    pc_d;
    logic             flush_q, flush_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Handshake outputs are combinational so a grant advances the PC with
    // single-cycle latency. A redirect suppresses the request, which is what
    // discards any grant arriving in the same cycle.
    assign imem_req  = (state_q == FETCH) && !stall && !redirect;
    assign imem_addr = pc_q;
    assign if_valid  = imem_req && imem_gnt;
    assign if_pc     = if_valid ? pc_q : '0;

    assign flush     = flush_q;
    assign halted    = halted_q;
    assign fetch_cnt = cnt_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            // Redirects during BOOT are ignored; the first fetch is RESET_PC.
            BOOT: state_d = FETCH;

            FETCH: begin
                if (redirect) begin
                    flush_d = 1'b1;
                    if (is_aligned(redirect_pc)) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                end else if (if_valid) begin
                    // Natural 32-bit overflow wraps 32'hFFFF_FFFC to 0.
                    pc_d  = pc_q + XLEN'(INSN_BYTES);
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HALT: state_d = HALT;

            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make all registers update from
            // the same pre-edge values, independent of statement order.
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl.
// Instance dut   : RESET_PC = 0, CNT_W = 32 (boot, wait states, stall,
//                  redirect, misaligned halt, async reset).
// Instance dut_w : RESET_PC = 32'hFFFF_FFF8, CNT_W = 2 (PC and counter wrap,
//                  async reset mid-cycle).
module tb_pc_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst, stall, redirect, imem_gnt;
    logic [31:0] redirect_pc;
    logic        imem_req, if_valid, flush, halted;
    logic [31:0] imem_addr, if_pc, fetch_cnt;

    // Wrap instance signals
    logic        w_rst, w_stall, w_redirect, w_gnt;
    logic [31:0] w_redirect_pc;
    logic        w_req, w_if_valid, w_flush, w_halted;
    logic [31:0] w_addr, w_if_pc;
    logic [1:0]  w_cnt;

    int errors = 0;
    int checks = 0;

    pc_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_gnt(imem_gnt),
        .imem_req(imem_req), .imem_addr(imem_addr), .if_valid(if_valid),
        .if_pc(if_pc), .flush(flush), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    pc_ctrl #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut_w (
        .clk(clk), .rst(w_rst), .stall(w_stall), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .imem_gnt(w_gnt),
        .imem_req(w_req), .imem_addr(w_addr), .if_valid(w_if_valid),
        .if_pc(w_if_pc), .flush(w_flush), .halted(w_halted), .fetch_cnt(w_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are then
    // changed and outputs sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
        w_rst = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0; w_gnt = 1'b1;

        // ---- reset state ----
        #1;
        check("rst_req",    32'(imem_req), 32'd0);
        check("rst_valid",  32'(if_valid), 32'd0);
        check("rst_if_pc",  if_pc,         32'h0);
        check("rst_flush",  32'(flush),    32'd0);
        check("rst_halted", 32'(halted),   32'd0);
        check("rst_cnt",    fetch_cnt,     32'd0);
        check("rst_addr",   imem_addr,     32'h0);
        tick(); tick();
        rst = 1'b0;

        // ---- BOOT cycle: no request even with grant ----
        #1;
        check("boot_req", 32'(imem_req), 32'd0);
        tick();

        // ---- back-to-back grants 0x0, 0x4 ----
        #1;
        check("f0_addr",  imem_addr,       32'h0);
        check("f0_req",   32'(imem_req),   32'd1);
        check("f0_valid", 32'(if_valid),   32'd1);
        check("f0_if_pc", if_pc,           32'h0);
        tick();
        #1;
        check("f1_addr",  imem_addr,       32'h4);
        check("f1_if_pc", if_pc,           32'h4);
        tick();

        // ---- wait states at 0x8 ----
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ws_addr",  imem_addr,     32'h8);
            check("ws_req",   32'(imem_req), 32'd1);
            check("ws_valid", 32'(if_valid), 32'd0);
            check("ws_cnt",   fetch_cnt,     32'd2);
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        check("ws_grant_valid", 32'(if_valid), 32'd1);
        check("ws_grant_if_pc", if_pc,         32'h8);
        tick();
        #1;
        check("after_ws_addr", imem_addr, 32'hC);
        check("after_ws_cnt",  fetch_cnt, 32'd3);
        tick();   // grant at 0xC -> pc 0x10, cnt 4

        // ---- stall at 0x10 for 2 cycles ----
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall_req",   32'(imem_req), 32'd0);
            check("stall_addr",  imem_addr,     32'h10);
            check("stall_valid", 32'(if_valid), 32'd0);
            tick();
        end
        check("stall_cnt", fetch_cnt, 32'd4);

        // ---- stall and redirect together: redirect wins ----
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("sr_req", 32'(imem_req), 32'd0);
        tick();
        stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0;
        #1;
        check("sr_addr",  imem_addr,  32'h100);
        check("sr_flush", 32'(flush), 32'd1);
        check("sr_cnt",   fetch_cnt,  32'd4);
        tick();
        #1;
        check("sr_flush_end", 32'(flush), 32'd0);
        check("sr_hold_addr", imem_addr,  32'h100);

        // ---- redirect with simultaneous grant ----
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        imem_gnt = 1'b1; redirect_pc = 32'h80;
        #1;
        check("rg_pre_addr", imem_addr,     32'h20);
        check("rg_valid",    32'(if_valid), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("rg_addr",  imem_addr,     32'h80);
        check("rg_cnt",   fetch_cnt,     32'd4);
        check("rg_flush", 32'(flush),    32'd1);
        check("rg_valid2", 32'(if_valid), 32'd1);
        tick();
        check("rg_cnt2",  fetch_cnt, 32'd5);
        check("rg_addr2", imem_addr, 32'h84);

        // ---- misaligned redirect -> HALT ----
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        #1;
        check("mis_halted", 32'(halted),   32'd1);
        check("mis_flush",  32'(flush),    32'd1);
        check("mis_addr",   imem_addr,     32'h84);
        check("mis_req",    32'(imem_req), 32'd0);
        tick();
        check("mis_flush_end", 32'(flush), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h200;   // ignored in HALT
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_req",    32'(imem_req), 32'd0);
            check("halt_valid",  32'(if_valid), 32'd0);
            check("halt_sticky", 32'(halted),   32'd1);
            tick();
        end
        check("halt_flush", 32'(flush),  32'd0);
        check("halt_addr",  imem_addr,   32'h84);
        check("halt_cnt",   fetch_cnt,   32'd5);

        // ---- async reset clears HALT without a clock edge ----
        #2;
        rst = 1'b1;
        #1;
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_addr",   imem_addr,   32'h0);
        check("arst_cnt",    fetch_cnt,   32'd0);
        tick();
        rst = 1'b0;

        // ---- redirect during BOOT is ignored ----
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        #1;
        check("boot_redir_addr",  imem_addr,  32'h0);
        check("boot_redir_flush", 32'(flush), 32'd0);
        check("boot_redir_req",   32'(imem_req), 32'd1);

        // ---- wrap instance: PC and counter wrap ----
        tick();
        w_rst = 1'b0;
        #1;
        check("w_boot_req", 32'(w_req), 32'd0);
        tick();
        #1;
        check("w_addr0", w_addr,        32'hFFFF_FFF8);
        check("w_valid0", 32'(w_if_valid), 32'd1);
        tick();
        check("w_addr1", w_addr,     32'hFFFF_FFFC);
        check("w_cnt1",  32'(w_cnt), 32'd1);
        tick();
        check("w_addr2", w_addr,     32'h0);
        check("w_cnt2",  32'(w_cnt), 32'd2);
        tick();
        check("w_addr3", w_addr,     32'h4);
        check("w_cnt3",  32'(w_cnt), 32'd3);
        tick();
        check("w_addr4", w_addr,     32'h8);
        check("w_cnt_wrap", 32'(w_cnt), 32'd0);
        check("w_req_pre", 32'(w_req), 32'd1);

        // ---- async reset mid-cycle drops request before next edge ----
        #2;
        w_rst = 1'b1;
        #1;
        check("w_arst_req",  32'(w_req),      32'd0);
        check("w_arst_valid", 32'(w_if_valid), 32'd0);
        check("w_arst_addr", w_addr,          32'hFFFF_FFF8);
        check("w_arst_cnt",  32'(w_cnt),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-stage program-counter controller for the pipelined RISC-V core. Owns the architectural fetch PC and sequences it against the instruction-memory request/grant handshake, hazard-unit stalls and EX-stage branch/jump redirects. Emits the fetch address, a one-cycle pipeline flush pulse on redirect, and a running count of accepted fetches. Sits between the hazard unit/EX stage and the instruction memory, feeding the IF/ID register.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- CNT_W, 32, width of the fetch counter

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit stall; hold PC, suppress request
- redirect  in  1  EX-stage taken branch/jump
- redirect_pc  in  32  target address, valid with redirect
- imem_gnt  in  1  memory accepts imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= current PC)
- if_valid  out  1  instruction at if_pc accepted this cycle
- if_pc  out  32  PC of accepted fetch
- flush  out  1  registered one-cycle pulse: kill IF/ID and ID/EX
- halted  out  1  sticky; misaligned redirect seen
- fetch_cnt  out  CNT_W  number of accepted fetches

## Operation
- States: BOOT, FETCH, HALT.
- BOOT: entered on reset; imem_req=0; leaves to FETCH on first clock edge after rst deasserts.
- FETCH: imem_req = !stall && !redirect; imem_addr = pc.
- Priority per cycle: redirect > stall > grant.
  - redirect && redirect_pc[1:0]==0: pc <= redirect_pc; flush <= 1 next cycle; any grant this cycle is discarded (if_valid=0, counter unchanged).
  - redirect && redirect_pc[1:0]!=0: go HALT, halted <= 1, pc unchanged, flush <= 1.
  - else stall: pc held, imem_req=0, if_valid=0.
  - else imem_req && imem_gnt: if_valid=1, if_pc=pc, pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), fetch_cnt <= fetch_cnt+1.
  - else (no grant): pc held, imem_req stays high.
- HALT: imem_req=0, if_valid=0, flush=0 after its pulse; exits only via rst.
- fetch_cnt wraps at 2^CNT_W−1 → 0 silently.
- Redirect in BOOT: ignored (pc stays RESET_PC).

## Timing
- Reset values (asynchronous): pc=RESET_PC, state=BOOT, imem_req=0, if_valid=0, if_pc=0, flush=0, halted=0, fetch_cnt=0.
- rst asserted mid-operation: all of the above immediately, without waiting for a clock edge; an in-flight grant is lost.
- imem_req, imem_addr, if_valid, if_pc combinational from state/inputs; pc, flush, halted, fetch_cnt registered.
- Grant-to-next-address latency: 1 cycle (back-to-back grants fetch pc, pc+4, pc+8 on consecutive cycles).
- Redirect-to-target-fetch: redirect in cycle N → imem_addr=redirect_pc and flush=1 in cycle N+1.
- imem_addr must be stable while imem_req=1 and imem_gnt=0.

## Structure
- Shared package pipe_pkg: state enum (BOOT, FETCH, HALT), XLEN=32, INSN_BYTES=4, RESET_PC default.
- Single module; no sub-module needed. The counter may be a small generic up_counter (enable, async reset, CNT_W) if the team already has one; otherwise inline.

## Test plan
- Reset/boot: rst=1 for 2 cycles, release, imem_gnt=1 always → cycle after release imem_req=0 (BOOT), then imem_addr 0x0,0x4,0x8; fetch_cnt=3 after 3 grants.
- Wait states: imem_gnt low for 3 cycles at pc=0x8 → imem_addr holds 0x8, imem_req=1, if_valid=0, fetch_cnt unchanged; on grant advances to 0xC.
- Stall vs. redirect: stall=1 at pc=0x10 for 2 cycles → imem_req=0, pc 0x10; then stall=1 and redirect=1, redirect_pc=0x100 same cycle → next cycle imem_addr=0x100, flush=1 for exactly one cycle.
- Redirect with simultaneous grant: pc=0x20, imem_gnt=1, redirect to 0x80 → if_valid=0, fetch_cnt unchanged, next imem_addr=0x80.
- Misaligned redirect: redirect_pc=0x102 → halted=1 sticky, imem_req=0 forever, flush one pulse; rst clears halted and pc=RESET_PC.
- Wrap: RESET_PC=32'hFFFF_FFF8, grants every cycle → addresses FFFF_FFF8, FFFF_FFFC, 0x0; async rst asserted mid-cycle drops imem_req before next edge.
